sonic_echo_emu: RTL and testbench
=================================

// Module: sonic_echo_emu
// PURPOSE
//   Behavioural HC-SR04 stand-in: the responder side of the ultrasonic trig/echo protocol.
//   Watches trig, validates the pulse width, waits a fixed burst delay, then drives echo high
//   for distance_cm * US_PER_CM clock cycles. Used for FPGA loopback of the ranging driver
//   and as the sensor model in driver benches. All timing is in c1MHz cycles (1 cycle = 1 us).
// PARAMETERS
//   TRIG_MIN_US    10     minimum synced trig high width (cycles) for a valid request
//   ECHO_DELAY_US  250    cycles from accepted trig fall to echo rise
//   US_PER_CM      58     echo cycles per cm of round trip; 6-bit value, range 1..63
//   TIMEOUT_US     38000  echo width when obj_present=0; 16-bit value
//   HOLDOFF_US     10000  dead time after echo falls; trig ignored during it
// PORTS
//   c1MHz        in   1   1 MHz clock; all logic on its rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   trig         in   1   trigger from the ranging driver; asynchronous, 2-FF synchronised
//   distance_cm  in   8   emulated target distance in cm; sampled at trig acceptance
//   obj_present  in   1   1: echo width from distance; 0: echo width = TIMEOUT_US
//   echo         out  1   registered echo pulse to the driver
//   busy         out  1   high from trig acceptance until HOLDOFF ends
//   trig_err     out  1   one-cycle pulse: trig fell after fewer than TRIG_MIN_US cycles
// BEHAVIOUR
//   Reset (rst_n=0, async): echo=0, busy=0, trig_err=0, state=IDLE, counters=0, sync FFs=0,
//     LFSR=16'hACE1. Reset mid-echo forces echo low immediately, with no glitch on release.
//   trig_s = trig after 2-FF sync; edge detection uses trig_s and a one-cycle-delayed copy.
//   FSM states IDLE, TRIG, DELAY, ECHO, HOLD:
//   - IDLE : on trig_s rise -> TRIG, trig width counter = 1.
//   - TRIG : counter +1 per cycle while trig_s=1; saturates at 8 bits (255). On trig_s fall:
//            if count >= TRIG_MIN_US, latch distance_cm/obj_present, busy=1, go to DELAY;
//            otherwise pulse trig_err for 1 cycle and go to IDLE.
//   - DELAY: cycle of the accepted fall = T. echo rises at T+ECHO_DELAY_US.
//   - ECHO : echo held high for exactly W cycles, then echo=0 -> HOLD.
//            W = obj ? max(dist,1)*US_PER_CM : TIMEOUT_US.
//            Product is 8x6 -> 14 bits, zero-extended into a 16-bit down-counter.
//            distance_cm=0 is clamped to 1 (W=US_PER_CM).
//   - HOLD : HOLDOFF_US cycles, then busy=0 -> IDLE. A trig_s rise in the same cycle
//            HOLD exits is ignored; the next rise is needed.
//   trig activity in DELAY/ECHO/HOLD is ignored: no restart, no trig_err.
//   distance_cm/obj_present changes after acceptance do not affect the current echo.
//   No overflow is possible: the max W is 255*63=16065 < 2^16.
// CONFIGURATION
//   SONIC_EMU_JITTER_EN defined: a 16-bit Galois LFSR (taps 16,14,13,11) steps every cycle.
//     At acceptance, W += LFSR[2:0], adding 0..7 cycles; this applies in the TIMEOUT case too.
//   Undefined: no LFSR is instantiated and W is exact as above.
//   Ports and the FSM are identical in both builds.
// TESTING
//   1 trig high 11 cyc, dist=100, obj=1 -> echo rises 250 cyc after synced fall, high exactly 5800 cyc
//   2 trig high 5 cyc -> one trig_err pulse; echo stays 0, busy stays 0, back in IDLE
//   3 obj=0, valid trig -> echo high exactly 38000 cyc; busy low 10000 cyc after echo fall
//   4 dist=0 -> echo 58 cyc; dist=255 -> echo 14790 cyc; change dist mid-echo -> width unchanged
//   5 second trig during ECHO and during HOLD -> ignored; trig after busy falls -> new echo
//   6 rst_n low mid-ECHO -> echo=0 and busy=0 at once; after release a valid trig works normally
//   7 JITTER_EN build, dist=100 -> every width in 5800..5807; undefined build -> always 5800

Source files
------------

// File: rtl/sonic_echo_emu.sv
// HC-SR04 responder model: validates a trig pulse, waits a fixed delay, then drives echo for a
// distance-derived width. Optional build macro SONIC_EMU_JITTER_EN adds 0..7 cycles of LFSR jitter.
module sonic_echo_emu #(
    parameter int TRIG_MIN_US   = 10,
    parameter int ECHO_DELAY_US = 250,
    parameter int US_PER_CM     = 58,
    parameter int TIMEOUT_US    = 38000,
    parameter int HOLDOFF_US    = 10000
) (
    input  logic       c1MHz,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [7:0] distance_cm,
    input  logic       obj_present,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    typedef enum logic [2:0] {IDLE, TRIG, DELAY, ECHO, HOLD} state_t;

    localparam logic [7:0]  TRIG_MIN = 8'(TRIG_MIN_US);
    // trig_s fell one cycle before the fall is seen, so the delay load absorbs that cycle
    localparam logic [15:0] DLY_LD   = 16'(ECHO_DELAY_US - 2);
    localparam logic [15:0] HOLD_LD  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] TMO      = 16'(TIMEOUT_US);
    localparam logic [13:0] UPC      = 14'(US_PER_CM);

    state_t      state;
    logic        sync1, trig_s, trig_d;
    logic [7:0]  tw;
    logic [15:0] tmr, w_len;
    logic        rise, fall;
    logic [7:0]  dist_c;
    logic [13:0] prod;
    logic [15:0] w_base, w_calc;

    assign rise   = trig_s & ~trig_d;
    assign fall   = ~trig_s & trig_d;
    assign dist_c = (distance_cm == 8'd0) ? 8'd1 : distance_cm;
    assign prod   = 14'(dist_c) * UPC;
    assign w_base = obj_present ? {2'b00, prod} : TMO;

`ifdef SONIC_EMU_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge c1MHz or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign w_calc = w_base + {13'd0, lfsr[2:0]};
`else
    assign w_calc = w_base;
`endif

    always_ff @(posedge c1MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            trig_s   <= 1'b0;
            trig_d   <= 1'b0;
            state    <= IDLE;
            tw       <= 8'd0;
            tmr      <= 16'd0;
            w_len    <= 16'd0;
            echo     <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            sync1    <= trig;
            trig_s   <= sync1;
            trig_d   <= trig_s;
            trig_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= TRIG;
                        tw    <= 8'd1;
                    end
                end
                TRIG: begin
                    if (fall) begin
                        if (tw >= TRIG_MIN) begin
                            w_len <= w_calc;
                            busy  <= 1'b1;
                            tmr   <= DLY_LD;
                            state <= DELAY;
                        end else begin
                            trig_err <= 1'b1;
                            state    <= IDLE;
                        end
                    end else if (trig_s && tw != 8'hFF) begin
                        tw <= tw + 8'd1;
                    end
                end
                DELAY: begin
                    if (tmr == 16'd0) begin
                        echo  <= 1'b1;
                        tmr   <= w_len - 16'd1;
                        state <= ECHO;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                ECHO: begin
                    if (tmr == 16'd0) begin
                        echo  <= 1'b0;
                        tmr   <= HOLD_LD;
                        state <= HOLD;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                HOLD: begin
                    if (tmr == 16'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_echo_emu.sv
// Directed + randomized bench for sonic_echo_emu against a width/latency reference model.
`timescale 1ns/1ps
module tb_sonic_echo_emu;

    localparam int EDLY     = 250;
    localparam int UPC      = 58;
    localparam int TMO      = 4000;
    localparam int HOLD     = 200;
    localparam int SYNC_LAT = 2;
    localparam int LAT_MAX  = 2000;
    localparam int WMAX     = 20000;
    localparam int HMAX     = 2000;
`ifdef SONIC_EMU_JITTER_EN
    localparam int JIT = 7;
`else
    localparam int JIT = 0;
`endif

    logic       c1MHz = 1'b0;
    logic       rst_n, trig, obj_present;
    logic [7:0] distance_cm;
    logic       echo, busy, trig_err;
    int         passed = 0;
    int         total  = 0;
    int         fails  = 0;

    always #5 c1MHz = ~c1MHz;

    sonic_echo_emu #(
        .TRIG_MIN_US(10), .ECHO_DELAY_US(EDLY), .US_PER_CM(UPC),
        .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD)
    ) dut (
        .c1MHz(c1MHz), .rst_n(rst_n), .trig(trig), .distance_cm(distance_cm),
        .obj_present(obj_present), .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    function automatic int model_width(int d, bit obj);
        if (!obj) return TMO;
        return ((d == 0) ? 1 : d) * UPC;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(string tag, int obs, int lo, int hi);
        total++;
        assert (obs >= lo && obs <= hi) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic trig_pulse(int n);
        @(negedge c1MHz);
        trig = 1'b1;
        repeat (n) @(negedge c1MHz);
        trig = 1'b0;
    endtask

    // mode 1: retrigger + distance change during echo and hold; mode 2: trig_s rise on hold exit
    task automatic run_echo(string tag, int n, int d, bit obj, int mode);
        int lat, w, h, exp_w;
        exp_w       = model_width(d, obj);
        distance_cm = 8'(d);
        obj_present = obj;
        trig_pulse(n);
        lat = 0;
        do begin @(posedge c1MHz); #1; lat++; end while (!echo && lat < LAT_MAX);
        chk({tag, "_lat"}, lat, SYNC_LAT + EDLY);
        chk({tag, "_busy"}, int'(busy), 1);
        w = 0;
        do begin
            @(posedge c1MHz); #1; w++;
            if (mode == 1) begin
                if (w == 5)  distance_cm = 8'd200;
                if (w == 20) trig = 1'b1;
                if (w == 35) trig = 1'b0;
            end
        end while (echo && w < WMAX);
        chk_w({tag, "_width"}, w, exp_w, exp_w + JIT);
        h = 0;
        do begin
            @(posedge c1MHz); #1; h++;
            if (mode == 1) begin
                if (h == 20) trig = 1'b1;
                if (h == 35) trig = 1'b0;
            end
            if (mode == 2 && h == HOLD - 3) trig = 1'b1;
        end while (busy && h < HMAX);
        chk({tag, "_hold"}, h, HOLD);
        if (mode == 2) begin
            repeat (15) @(negedge c1MHz);
            trig = 1'b0;
        end
    endtask

    task automatic short_pulse(string tag, int n);
        int errs = 0, first = 0, ech = 0, bsy = 0;
        trig_pulse(n);
        for (int i = 1; i <= 300; i++) begin
            @(posedge c1MHz); #1;
            if (trig_err) begin errs++; if (first == 0) first = i; end
            if (echo) ech++;
            if (busy) bsy++;
        end
        chk({tag, "_errs"}, errs, 1);
        chk({tag, "_errpos"}, first, 3);
        chk({tag, "_echo"}, ech, 0);
        chk({tag, "_busy"}, bsy, 0);
    endtask

    task automatic quiet(string tag, int n);
        int errs = 0, ech = 0, bsy = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge c1MHz); #1;
            if (trig_err) errs++;
            if (echo) ech++;
            if (busy) bsy++;
        end
        chk({tag, "_errs"}, errs, 0);
        chk({tag, "_echo"}, ech, 0);
        chk({tag, "_busy"}, bsy, 0);
    endtask

    initial begin
        int lat, d, n;
        rst_n = 1'b0; trig = 1'b0; distance_cm = 8'd0; obj_present = 1'b1;
        repeat (3) @(negedge c1MHz);
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(trig_err), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge c1MHz);

        run_echo("d100", 11, 100, 1'b1, 0);
        short_pulse("short5", 5);
        short_pulse("short9", 9);
        run_echo("min10", 10, 1, 1'b1, 0);
        run_echo("sat300", 300, 3, 1'b1, 0);
        run_echo("noobj", 11, 100, 1'b0, 0);
        run_echo("d0", 12, 0, 1'b1, 0);
        run_echo("d255", 11, 255, 1'b1, 0);
        run_echo("retrig", 11, 20, 1'b1, 1);
        run_echo("after_retrig", 11, 20, 1'b1, 0);
        run_echo("hold_edge", 11, 5, 1'b1, 2);
        quiet("hold_edge_q", 300);
        run_echo("hold_next", 11, 7, 1'b1, 0);

        distance_cm = 8'd50; obj_present = 1'b1;
        trig_pulse(11);
        lat = 0;
        do begin @(posedge c1MHz); #1; lat++; end while (!echo && lat < LAT_MAX);
        chk("midrst_lat", lat, SYNC_LAT + EDLY);
        repeat (100) @(posedge c1MHz);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_echo", int'(echo), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge c1MHz);
        rst_n = 1'b1;
        quiet("midrst_q", 20);
        run_echo("after_rst", 11, 30, 1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(0, 40));
            n = int'($urandom_range(10, 40));
            run_echo($sformatf("rnd%0d_d%0d", i, d), n, d, 1'b1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            n = int'($urandom_range(1, 9));
            short_pulse($sformatf("rshort%0d_n%0d", i, n), n);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
